// File: rtl/fft_power_spectrum_if.sv
// Stream bundle between fft_power_spectrum and its neighbours: the complex input stream
// from fft_core and the power output stream. slave is the block's view, master the environment's.
interface fft_power_spectrum_if #(
  parameter int unsigned IN_W      = 24,
  parameter int unsigned NFFT_LOG2 = 7
);

  logic [2*IN_W-1:0]    s_axis_tdata;
  logic                 s_axis_tvalid;
  logic                 s_axis_tlast;
  logic                 s_axis_tready;

  logic [2*IN_W-1:0]    m_axis_tdata;
  logic [NFFT_LOG2-1:0] m_axis_tuser;
  logic                 m_axis_tvalid;
  logic                 m_axis_tlast;
  logic                 m_axis_tready;

  modport slave (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    input  s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata,
    output m_axis_tuser,
    output m_axis_tvalid,
    output m_axis_tlast,
    input  m_axis_tready
  );

  modport master (
    output s_axis_tdata,
    output s_axis_tvalid,
    output s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata,
    input  m_axis_tuser,
    input  m_axis_tvalid,
    input  m_axis_tlast,
    output m_axis_tready
  );

endinterface

// File: rtl/fft_power_spectrum.sv
// Per-bin power re^2+im^2 of fft_core output through a stalling 3-stage pipeline, with frame
// length checking. Define PEAK_DETECT_EN to add per-frame peak bin reporting.
module fft_power_spectrum #(
  parameter int unsigned IN_W      = 24,
  parameter int unsigned NFFT_LOG2 = 7
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  fft_power_spectrum_if.slave      axis,
  output logic                     event_tlast_unexpected,
  output logic                     event_tlast_missing,
  output logic [NFFT_LOG2-1:0]     peak_bin,
  output logic [2*IN_W-1:0]        peak_power,
  output logic                     peak_valid
);

  localparam int unsigned PW  = 2 * IN_W;
  localparam int unsigned SqW = 2 * IN_W - 1;
  localparam logic [NFFT_LOG2-1:0] LastBin = '1;

  // Whole pipeline advances together; a stalled output freezes every stage.
  logic en;
  logic in_fire;

  logic signed [IN_W-1:0] in_re;
  logic signed [IN_W-1:0] in_im;

  // Stage 1
  logic                   s1_valid_q;
  logic signed [IN_W-1:0] s1_re_q;
  logic signed [IN_W-1:0] s1_im_q;
  logic                   s1_last_q;
  logic [NFFT_LOG2-1:0]   s1_bin_q;

  // Stage 2
  logic                   s2_valid_q;
  logic [SqW-1:0]         s2_re_sq_q;
  logic [SqW-1:0]         s2_im_sq_q;
  logic                   s2_last_q;
  logic [NFFT_LOG2-1:0]   s2_bin_q;

  // Stage 3 (output)
  logic                   m_valid_q;
  logic [PW-1:0]          m_data_q;
  logic [NFFT_LOG2-1:0]   m_user_q;
  logic                   m_last_q;

  logic [NFFT_LOG2-1:0]   bin_cnt_q;
  logic                   unexp_q;
  logic                   miss_q;

  logic signed [PW-1:0]   re_ext;
  logic signed [PW-1:0]   im_ext;
  logic [SqW-1:0]         re_sq;
  logic [SqW-1:0]         im_sq;
  logic [PW-1:0]          pwr_sum;

  assign en                 = ~m_valid_q | axis.m_axis_tready;
  assign axis.s_axis_tready = en;
  assign in_fire            = axis.s_axis_tvalid & en;

  assign in_re = axis.s_axis_tdata[IN_W-1:0];
  assign in_im = axis.s_axis_tdata[PW-1:IN_W];

  // A square of an IN_W-bit signed value peaks at 2^(2*IN_W-2), so SqW unsigned bits suffice.
  assign re_ext  = {{IN_W{s1_re_q[IN_W-1]}}, s1_re_q};
  assign im_ext  = {{IN_W{s1_im_q[IN_W-1]}}, s1_im_q};
  assign re_sq   = SqW'(re_ext * re_ext);
  assign im_sq   = SqW'(im_ext * im_ext);
  assign pwr_sum = {1'b0, s2_re_sq_q} + {1'b0, s2_im_sq_q};

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      s1_valid_q <= 1'b0;
      s1_re_q    <= '0;
      s1_im_q    <= '0;
      s1_last_q  <= 1'b0;
      s1_bin_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_re_sq_q <= '0;
      s2_im_sq_q <= '0;
      s2_last_q  <= 1'b0;
      s2_bin_q   <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_user_q   <= '0;
      m_last_q   <= 1'b0;
    end else if (en) begin
      s1_valid_q <= axis.s_axis_tvalid;
      if (axis.s_axis_tvalid) begin
        s1_re_q   <= in_re;
        s1_im_q   <= in_im;
        s1_last_q <= axis.s_axis_tlast;
        s1_bin_q  <= bin_cnt_q;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_re_sq_q <= re_sq;
        s2_im_sq_q <= im_sq;
        s2_last_q  <= s1_last_q;
        s2_bin_q   <= s1_bin_q;
      end
      m_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        m_data_q <= pwr_sum;
        m_user_q <= s2_bin_q;
        m_last_q <= s2_last_q;
      end
    end
  end

  assign axis.m_axis_tvalid = m_valid_q;
  assign axis.m_axis_tdata  = m_data_q;
  assign axis.m_axis_tuser  = m_user_q;
  assign axis.m_axis_tlast  = m_last_q;

  // Frame-length check runs on accepted input beats, so it never waits on output backpressure.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      bin_cnt_q <= '0;
      unexp_q   <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      unexp_q <= 1'b0;
      miss_q  <= 1'b0;
      if (in_fire) begin
        if (axis.s_axis_tlast) begin
          bin_cnt_q <= '0;
          unexp_q   <= (bin_cnt_q != LastBin);
        end else if (bin_cnt_q == LastBin) begin
          bin_cnt_q <= '0;
          miss_q    <= 1'b1;
        end else begin
          bin_cnt_q <= bin_cnt_q + NFFT_LOG2'(1);
        end
      end
    end
  end

  assign event_tlast_unexpected = unexp_q;
  assign event_tlast_missing    = miss_q;

`ifdef PEAK_DETECT_EN
  logic                 out_fire;
  logic                 beat_wins;
  logic                 trk_have_q;
  logic [NFFT_LOG2-1:0] trk_bin_q;
  logic [PW-1:0]        trk_pwr_q;
  logic [NFFT_LOG2-1:0] peak_bin_q;
  logic [PW-1:0]        peak_pwr_q;
  logic                 peak_valid_q;

  assign out_fire  = m_valid_q & axis.m_axis_tready;
  // Strict compare keeps the earliest (lowest) bin on ties.
  assign beat_wins = ~trk_have_q | (m_data_q > trk_pwr_q);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      trk_have_q   <= 1'b0;
      trk_bin_q    <= '0;
      trk_pwr_q    <= '0;
      peak_bin_q   <= '0;
      peak_pwr_q   <= '0;
      peak_valid_q <= 1'b0;
    end else begin
      peak_valid_q <= 1'b0;
      if (out_fire) begin
        if (m_last_q) begin
          peak_valid_q <= 1'b1;
          peak_bin_q   <= beat_wins ? m_user_q : trk_bin_q;
          peak_pwr_q   <= beat_wins ? m_data_q : trk_pwr_q;
          trk_have_q   <= 1'b0;
          trk_bin_q    <= '0;
          trk_pwr_q    <= '0;
        end else if (beat_wins) begin
          trk_have_q <= 1'b1;
          trk_bin_q  <= m_user_q;
          trk_pwr_q  <= m_data_q;
        end
      end
    end
  end

  assign peak_bin   = peak_bin_q;
  assign peak_power = peak_pwr_q;
  assign peak_valid = peak_valid_q;
`else
  assign peak_bin   = '0;
  assign peak_power = '0;
  assign peak_valid = 1'b0;
`endif

endmodule

// File: tb/tb_fft_power_spectrum.sv
// Bench for fft_power_spectrum: directed frames against a transaction-level power/bin/event model.
module tb_fft_power_spectrum;

  localparam int unsigned IN_W      = 24;
  localparam int unsigned NFFT_LOG2 = 7;
  localparam int unsigned PW        = 2 * IN_W;
  localparam int          FrameLen  = 1 << NFFT_LOG2;

  logic                 aclk    = 1'b0;
  logic                 aresetn = 1'b0;
  logic                 event_tlast_unexpected;
  logic                 event_tlast_missing;
  logic [NFFT_LOG2-1:0] peak_bin;
  logic [PW-1:0]        peak_power;
  logic                 peak_valid;

  fft_power_spectrum_if #(.IN_W(IN_W), .NFFT_LOG2(NFFT_LOG2)) axis ();

  fft_power_spectrum #(.IN_W(IN_W), .NFFT_LOG2(NFFT_LOG2)) dut (
    .aclk                   (aclk),
    .aresetn                (aresetn),
    .axis                   (axis),
    .event_tlast_unexpected (event_tlast_unexpected),
    .event_tlast_missing    (event_tlast_missing),
    .peak_bin               (peak_bin),
    .peak_power             (peak_power),
    .peak_valid             (peak_valid)
  );

  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] pwr;
    int          bin;
    bit          last;
  } beat_t;

  beat_t       exp_q[$];
  int          model_bin  = 0;
  bit          pend_unexp = 1'b0;
  bit          pend_miss  = 1'b0;
  bit          pend_pv    = 1'b0;
  int          exp_pbin   = 0;
  logic [63:0] exp_ppwr   = '0;
  int          cnt_unexp  = 0;
  int          cnt_miss   = 0;
  int          cnt_last   = 0;
  logic [63:0] out_data_log[$];
  int          out_user_log[$];
  logic [63:0] frame_pwr[$];
  int          frame_bin[$];

  bit                   prev_stall = 1'b0;
  logic [PW-1:0]        prev_data;
  logic [NFFT_LOG2-1:0] prev_user;
  logic                 prev_last;

  always @(negedge aclk) begin
    logic   in_fire;
    logic   out_fire;
    longint re;
    longint im;
    beat_t  b;
    beat_t  e;
    int     best;
    in_fire  = axis.s_axis_tvalid && axis.s_axis_tready;
    out_fire = axis.m_axis_tvalid && axis.m_axis_tready;

    check("s_tready", axis.s_axis_tready, !axis.m_axis_tvalid || axis.m_axis_tready);
    check("event_unexpected", event_tlast_unexpected, pend_unexp);
    check("event_missing", event_tlast_missing, pend_miss);
    check("peak_valid", peak_valid, pend_pv);
    check("peak_bin", peak_bin, exp_pbin);
    check("peak_power", peak_power, exp_ppwr);
    cnt_unexp += int'(event_tlast_unexpected);
    cnt_miss  += int'(event_tlast_missing);
    pend_unexp = 1'b0;
    pend_miss  = 1'b0;
    pend_pv    = 1'b0;

    if (prev_stall) begin
      check("hold_valid", axis.m_axis_tvalid, 1);
      check("hold_data", axis.m_axis_tdata, prev_data);
      check("hold_user", axis.m_axis_tuser, prev_user);
      check("hold_last", axis.m_axis_tlast, prev_last);
    end

    if (!aresetn) begin
      exp_q.delete();
      frame_pwr.delete();
      frame_bin.delete();
      model_bin  = 0;
      exp_pbin   = 0;
      exp_ppwr   = '0;
      prev_stall = 1'b0;
    end else begin
      prev_stall = axis.m_axis_tvalid && !axis.m_axis_tready;
      prev_data  = axis.m_axis_tdata;
      prev_user  = axis.m_axis_tuser;
      prev_last  = axis.m_axis_tlast;

      if (out_fire) begin
        if (exp_q.size() == 0) begin
          check("spurious_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", axis.m_axis_tdata, e.pwr);
          check("out_user", axis.m_axis_tuser, e.bin);
          check("out_last", axis.m_axis_tlast, e.last);
        end
        out_data_log.push_back(axis.m_axis_tdata);
        out_user_log.push_back(int'(axis.m_axis_tuser));
        if (axis.m_axis_tlast) cnt_last++;
`ifdef PEAK_DETECT_EN
        frame_pwr.push_back(axis.m_axis_tdata);
        frame_bin.push_back(int'(axis.m_axis_tuser));
        if (axis.m_axis_tlast) begin
          best = 0;
          for (int i = 1; i < frame_pwr.size(); i++) begin
            if (frame_pwr[i] > frame_pwr[best]) best = i;
          end
          exp_pbin = frame_bin[best];
          exp_ppwr = frame_pwr[best];
          pend_pv  = 1'b1;
          frame_pwr.delete();
          frame_bin.delete();
        end
`endif
      end

      if (in_fire) begin
        re     = $signed(axis.s_axis_tdata[IN_W-1:0]);
        im     = $signed(axis.s_axis_tdata[PW-1:IN_W]);
        b.pwr  = re * re + im * im;
        b.bin  = model_bin;
        b.last = axis.s_axis_tlast;
        exp_q.push_back(b);
        if (axis.s_axis_tlast) begin
          pend_unexp = (model_bin != FrameLen - 1);
          model_bin  = 0;
        end else if (model_bin == FrameLen - 1) begin
          pend_miss = 1'b1;
          model_bin = 0;
        end else begin
          model_bin++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int rdy_mode = 0;
  int rdy_cnt  = 0;

  always @(posedge aclk) begin
    #1;
    rdy_cnt = rdy_cnt + 1;
    if (rdy_mode == 0) axis.m_axis_tready = 1'b1;
    else               axis.m_axis_tready = ((rdy_cnt / 3) % 2) == 0;
  end

  task automatic send(input int re, input int im, input bit last);
    bit done;
    int guard;
    axis.s_axis_tdata  = {im[IN_W-1:0], re[IN_W-1:0]};
    axis.s_axis_tvalid = 1'b1;
    axis.s_axis_tlast  = last;
    done  = 1'b0;
    guard = 0;
    while (!done) begin
      @(negedge aclk);
      done = axis.s_axis_tready;
      @(posedge aclk);
      #1;
      guard++;
      if (!done && guard > 50) begin
        check("input_accept_timeout", 0, 1);
        done = 1'b1;
      end
    end
  endtask

  task automatic idle();
    axis.s_axis_tvalid = 1'b0;
    axis.s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge aclk);
      k++;
    end
    @(negedge aclk);
    check(name, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    idle();
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  initial begin
    int snap_u;
    int snap_m;
    int snap_l;
    bit seen;
    axis.s_axis_tdata  = '0;
    axis.s_axis_tvalid = 1'b0;
    axis.s_axis_tlast  = 1'b0;
    axis.m_axis_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;

    // Reset state
    @(negedge aclk);
    check("rst_tvalid", axis.m_axis_tvalid, 0);
    check("rst_tdata", axis.m_axis_tdata, 0);
    check("rst_tuser", axis.m_axis_tuser, 0);
    check("rst_tlast", axis.m_axis_tlast, 0);
    check("rst_tready", axis.s_axis_tready, 1);
    @(posedge aclk);
    #1;

    // Test 1: single beat, latency 3
    send(3, -4, 1'b0);
    idle();
    @(negedge aclk);
    check("t1_lat_c1", axis.m_axis_tvalid, 0);
    @(negedge aclk);
    check("t1_lat_c2", axis.m_axis_tvalid, 0);
    @(negedge aclk);
    check("t1_lat_c3", axis.m_axis_tvalid, 1);
    check("t1_data", axis.m_axis_tdata, 25);
    check("t1_user", axis.m_axis_tuser, 0);
    @(posedge aclk);
    #1;

    // Test 2: extreme magnitudes
    out_data_log.delete();
    out_user_log.delete();
    send(-8388608, -8388608, 1'b0);
    send(8388607, 8388607, 1'b0);
    idle();
    wait_drain("t2_drain");
    check("t2_count", out_data_log.size(), 2);
    if (out_data_log.size() == 2) begin
      check("t2_min_sq", out_data_log[0], 64'd140737488355328);
      check("t2_max_sq", out_data_log[1], 64'd140737454800898);
    end
    @(posedge aclk);
    #1;
    do_reset();

    // Test 3: full frame under toggling backpressure
    out_data_log.delete();
    out_user_log.delete();
    snap_u = cnt_unexp;
    snap_m = cnt_miss;
    snap_l = cnt_last;
    rdy_mode = 1;
    for (int i = 0; i < FrameLen; i++) send(i + 1, -i, i == FrameLen - 1);
    idle();
    wait_drain("t3_drain");
    rdy_mode = 0;
    check("t3_count", out_user_log.size(), FrameLen);
    if (out_user_log.size() == FrameLen) begin
      for (int i = 0; i < FrameLen; i++) check("t3_user_order", out_user_log[i], i);
    end
    check("t3_tlast_count", cnt_last - snap_l, 1);
    check("t3_no_unexp", cnt_unexp - snap_u, 0);
    check("t3_no_miss", cnt_miss - snap_m, 0);
    @(posedge aclk);
    #1;

    // Test 4: early tlast, then a frame without tlast
    out_user_log.delete();
    snap_u = cnt_unexp;
    snap_m = cnt_miss;
    for (int i = 0; i <= 10; i++) send(i, i, i == 10);
    for (int i = 0; i < FrameLen; i++) send(2, 1, 1'b0);
    idle();
    wait_drain("t4_drain");
    repeat (2) @(negedge aclk);
    check("t4_unexp_once", cnt_unexp - snap_u, 1);
    check("t4_miss_once", cnt_miss - snap_m, 1);
    check("t4_count", out_user_log.size(), 11 + FrameLen);
    if (out_user_log.size() == 11 + FrameLen) begin
      check("t4_restart_bin", out_user_log[11], 0);
      check("t4_end_bin", out_user_log[10 + FrameLen], FrameLen - 1);
    end
    @(posedge aclk);
    #1;

    // Test 5: reset mid-frame
    for (int i = 0; i <= 50; i++) send(i, 0, 1'b0);
    idle();
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check("t5_tvalid", axis.m_axis_tvalid, 0);
    check("t5_tdata", axis.m_axis_tdata, 0);
    check("t5_tuser", axis.m_axis_tuser, 0);
    check("t5_tlast", axis.m_axis_tlast, 0);
    check("t5_unexp", event_tlast_unexpected, 0);
    check("t5_miss", event_tlast_missing, 0);
    out_data_log.delete();
    out_user_log.delete();
    @(posedge aclk);
    #1;
    send(5, 0, 1'b0);
    idle();
    wait_drain("t5_drain");
    repeat (3) @(negedge aclk);
    check("t5_count", out_user_log.size(), 1);
    if (out_user_log.size() == 1) begin
      check("t5_bin0", out_user_log[0], 0);
      check("t5_data", out_data_log[0], 25);
    end
    @(posedge aclk);
    #1;

`ifdef PEAK_DETECT_EN
    // Test 6: peak detection, tie keeps lower bin
    do_reset();
    for (int i = 0; i < FrameLen; i++) send((i == 5 || i == 9) ? 1000 : 1, 0, i == FrameLen - 1);
    idle();
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge aclk);
      if (peak_valid) seen = 1'b1;
    end
    check("t6_peak_pulse", seen, 1);
    check("t6_peak_bin", peak_bin, 5);
    check("t6_peak_power", peak_power, 1000000);
    wait_drain("t6_drain");
`else
    seen = 1'b0;
`endif

    repeat (5) @(negedge aclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
